// File: rtl/spi_master_transmitter.sv
// SPI mode-0 master: frames a byte stream onto CS/SCLK/MOSI with divided SCLK
// and captures MISO through a two-flop synchronizer.
module spi_master_transmitter #(
    parameter int CLK_DIV_HALF = 8,
    parameter int CS_SETUP     = 8,
    parameter int CS_HOLD      = 8,
    parameter int CS_IDLE      = 16
) (
    input  logic       i_master_clk,
    input  logic       w_reset,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_last,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_busy,
    output logic       o_spi_cs_n,
    output logic       o_spi_clk,
    output logic       o_spi_mosi,
    input  logic       i_spi_miso
);
    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, NEXT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LOAD   = 8'(CLK_DIV_HALF - 1);
    localparam logic [7:0] SETUP_LOAD = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(CS_HOLD - 1);
    localparam logic [7:0] IDLE_LOAD  = 8'(CS_IDLE - 1);

    state_t     state, state_nxt;
    logic [7:0] phase, phase_nxt;
    logic [2:0] bit_cnt, bit_nxt;
    logic [7:0] tx_byte, tx_nxt;
    logic       last_q, last_nxt;
    logic [7:0] rx_sr, rx_sr_nxt;
    logic [7:0] rx_data_nxt;
    logic       rx_valid_nxt, cs_n_nxt, sclk_nxt, mosi_nxt;
    logic       miso_p0, miso_p1;
    logic       phase_done;
    logic       accept;

    assign o_tx_ready = (state == IDLE) || (state == NEXT);
    assign o_busy     = (state != IDLE);
    assign accept     = i_tx_valid && o_tx_ready;
    assign phase_done = (phase == 8'd0);

    // MISO synchronizer stage boundary
    always_ff @(posedge i_master_clk) begin
        miso_p0 <= i_spi_miso;
        miso_p1 <= miso_p0;
    end

    always_ff @(posedge i_master_clk) begin
        tx_byte <= tx_nxt;
        last_q  <= last_nxt;
        rx_sr   <= rx_sr_nxt;
        if (w_reset) begin
            state      <= IDLE;
            phase      <= 8'd0;
            bit_cnt    <= 3'd7;
            o_spi_cs_n <= 1'b1;
            o_spi_clk  <= 1'b0;
            o_spi_mosi <= 1'b0;
            o_rx_data  <= 8'd0;
            o_rx_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            bit_cnt    <= bit_nxt;
            o_spi_cs_n <= cs_n_nxt;
            o_spi_clk  <= sclk_nxt;
            o_spi_mosi <= mosi_nxt;
            o_rx_data  <= rx_data_nxt;
            o_rx_valid <= rx_valid_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase_done ? phase : phase - 8'd1;
        bit_nxt      = bit_cnt;
        tx_nxt       = tx_byte;
        last_nxt     = last_q;
        rx_sr_nxt    = rx_sr;
        rx_data_nxt  = o_rx_data;
        rx_valid_nxt = 1'b0;
        cs_n_nxt     = o_spi_cs_n;
        sclk_nxt     = o_spi_clk;
        mosi_nxt     = o_spi_mosi;
        case (state)
            IDLE: begin
                if (accept) begin
                    tx_nxt    = i_tx_data;
                    last_nxt  = i_tx_last;
                    bit_nxt   = 3'd7;
                    cs_n_nxt  = 1'b0;
                    mosi_nxt  = i_tx_data[7];
                    phase_nxt = SETUP_LOAD;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (phase_done) begin
                    phase_nxt = DIV_LOAD;
                    state_nxt = LOW;
                end
            end
            LOW: begin
                if (phase_done) begin
                    rx_sr_nxt = {rx_sr[6:0], miso_p1};
                    sclk_nxt  = 1'b1;
                    phase_nxt = DIV_LOAD;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (phase_done) begin
                    sclk_nxt = 1'b0;
                    if (bit_cnt == 3'd0) begin
                        // MOSI keeps bit 0 while waiting for the next byte or the CS hold
                        rx_data_nxt  = rx_sr;
                        rx_valid_nxt = 1'b1;
                        phase_nxt    = HOLD_LOAD;
                        state_nxt    = last_q ? HOLD : NEXT;
                    end else begin
                        bit_nxt   = bit_cnt - 3'd1;
                        mosi_nxt  = tx_byte[bit_cnt - 3'd1];
                        phase_nxt = DIV_LOAD;
                        state_nxt = LOW;
                    end
                end
            end
            NEXT: begin
                if (accept) begin
                    tx_nxt    = i_tx_data;
                    last_nxt  = i_tx_last;
                    bit_nxt   = 3'd7;
                    mosi_nxt  = i_tx_data[7];
                    phase_nxt = DIV_LOAD;
                    state_nxt = LOW;
                end
            end
            HOLD: begin
                if (phase_done) begin
                    cs_n_nxt  = 1'b1;
                    phase_nxt = IDLE_LOAD;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (phase_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_master_transmitter.sv
// Bench for spi_master_transmitter: MISO looped to MOSI, random frames against
// a frame-level timing/data model, plus a CLK_DIV_HALF=1 instance with MISO tied high.
module tb_spi_master_transmitter;
    localparam int DIV    = 8;
    localparam int SETUP  = 8;
    localparam int HOLD   = 8;
    localparam int IDLE   = 16;
    localparam int BUDGET = 4000;

    logic       clk = 1'b0;
    logic       w_reset = 1'b1;
    logic [7:0] i_tx_data = 8'd0;
    logic       i_tx_last = 1'b0;
    logic       i_tx_valid = 1'b0;
    logic       tx1_valid = 1'b0;

    logic       o_tx_ready, o_rx_valid, o_busy, o_spi_cs_n, o_spi_clk, o_spi_mosi;
    logic [7:0] o_rx_data;
    logic       ready1, rx_valid1, busy1, cs_n1, sclk1, mosi1;
    logic [7:0] rx_data1;

    int checks = 0;
    int errors = 0;

    spi_master_transmitter #(.CLK_DIV_HALF(DIV), .CS_SETUP(SETUP), .CS_HOLD(HOLD), .CS_IDLE(IDLE)) dut (
        .i_master_clk(clk), .w_reset(w_reset),
        .i_tx_data(i_tx_data), .i_tx_last(i_tx_last), .i_tx_valid(i_tx_valid),
        .o_tx_ready(o_tx_ready), .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
        .o_busy(o_busy), .o_spi_cs_n(o_spi_cs_n), .o_spi_clk(o_spi_clk),
        .o_spi_mosi(o_spi_mosi), .i_spi_miso(o_spi_mosi)
    );

    spi_master_transmitter #(.CLK_DIV_HALF(1), .CS_SETUP(SETUP), .CS_HOLD(HOLD), .CS_IDLE(IDLE)) dut1 (
        .i_master_clk(clk), .w_reset(w_reset),
        .i_tx_data(i_tx_data), .i_tx_last(i_tx_last), .i_tx_valid(tx1_valid),
        .o_tx_ready(ready1), .o_rx_data(rx_data1), .o_rx_valid(rx_valid1),
        .o_busy(busy1), .o_spi_cs_n(cs_n1), .o_spi_clk(sclk1),
        .o_spi_mosi(mosi1), .i_spi_miso(1'b1)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Bus monitor: records what the wires did, sampled on the falling clock edge
    int         rises = 0, low_run = 0, cs_run = 0, busy_run = 0, pre_cnt = 0;
    int         last_cs = 0, last_busy = 0, first_pre = 0;
    bit         sawfall = 0, rose = 0, prev_sclk = 0, prev_cs = 1, prev_busy = 0;
    logic       mosi_q[$];
    logic [7:0] rx_q[$];
    int         low_q[$];

    initial forever begin
        @(negedge clk);
        if (o_spi_clk && !prev_sclk) begin
            rises++;
            mosi_q.push_back(o_spi_mosi);
            if (sawfall) low_q.push_back(low_run);
            if (!rose) begin first_pre = pre_cnt; rose = 1; end
        end
        if (!o_spi_clk && prev_sclk) begin low_run = 1; sawfall = 1; end
        else if (!o_spi_clk) low_run++;
        if (!o_spi_cs_n) begin
            cs_run++;
            if (!rose && !o_spi_clk) pre_cnt++;
        end else begin
            if (!prev_cs) last_cs = cs_run;
            cs_run = 0; sawfall = 0; rose = 0; pre_cnt = 0;
        end
        if (o_busy) busy_run++;
        else begin
            if (prev_busy) last_busy = busy_run;
            busy_run = 0;
        end
        if (o_rx_valid) rx_q.push_back(o_rx_data);
        prev_sclk = o_spi_clk; prev_cs = o_spi_cs_n; prev_busy = o_busy;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    int stall_bad = 0;

    // Offer one byte; d>0 withholds valid for d cycles after the block becomes ready
    task automatic send(input logic [7:0] b, input logic l, input int d);
        int n = 0;
        if (d > 0) begin
            i_tx_valid = 1'b0;
            while (!o_tx_ready && n < BUDGET) begin tick(); n++; end
            repeat (d) begin
                tick();
                if (o_spi_cs_n || o_spi_clk || o_rx_valid || !o_tx_ready) stall_bad++;
            end
        end
        i_tx_valid = 1'b1;
        i_tx_data  = b;
        i_tx_last  = l;
        while (!o_tx_ready && n < BUDGET) begin tick(); n++; end
        if (n >= BUDGET) check_eq("ready_timeout", o_tx_ready, 1);
        tick();
        i_tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (o_busy && n < BUDGET) begin tick(); n++; end
        check_eq({tag, "_idle"}, o_busy, 0);
    endtask

    logic [7:0] fb[8];
    int         fd[8];

    task automatic run_frame(input string tag, input int n);
        int r0, m0, x0, l0, gap, exp_cs, idx, exp_low;
        logic [7:0] got;
        r0 = rises; m0 = mosi_q.size(); x0 = rx_q.size(); l0 = low_q.size();
        stall_bad = 0;
        gap = 0;
        for (int k = 1; k < n; k++) gap += 1 + fd[k];
        exp_cs = SETUP + 16 * DIV * n + gap + HOLD;
        for (int k = 0; k < n; k++) send(fb[k], k == n - 1, (k == 0) ? 0 : fd[k]);
        wait_idle(tag);
        check_eq({tag, "_rises"}, rises - r0, 8 * n);
        check_eq({tag, "_strobes"}, rx_q.size() - x0, n);
        check_eq({tag, "_first_rise"}, first_pre, SETUP + DIV);
        check_eq({tag, "_cs_low"}, last_cs, exp_cs);
        check_eq({tag, "_busy"}, last_busy, exp_cs + IDLE);
        if (gap != n - 1) check_eq({tag, "_stall"}, stall_bad, 0);
        for (int k = 0; k < n; k++) begin
            got = 8'd0;
            for (int i = 0; i < 8; i++) begin
                idx = m0 + 8 * k + i;
                got = {got[6:0], (idx < mosi_q.size()) ? mosi_q[idx] : 1'bx};
            end
            check_eq($sformatf("%s_mosi%0d", tag, k), got, fb[k]);
            idx = x0 + k;
            check_eq($sformatf("%s_rx%0d", tag, k), (idx < rx_q.size()) ? rx_q[idx] : 8'hxx, fb[k]);
        end
        for (int j = 0; j < 8 * n - 1; j++) begin
            exp_low = ((j + 1) % 8 == 0) ? DIV + 1 + fd[(j + 1) / 8] : DIV;
            idx = l0 + j;
            check_eq($sformatf("%s_low%0d", tag, j), (idx < low_q.size()) ? low_q[idx] : -1, exp_low);
        end
    endtask

    initial begin
        int r0, x0, n, flips, strobes;
        logic [7:0] mb, rxb;

        repeat (3) tick();
        check_eq("rst_cs_n", o_spi_cs_n, 1);
        check_eq("rst_sclk", o_spi_clk, 0);
        check_eq("rst_mosi", o_spi_mosi, 0);
        check_eq("rst_rx_data", o_rx_data, 0);
        check_eq("rst_rx_valid", o_rx_valid, 0);
        check_eq("rst_ready", o_tx_ready, 1);
        check_eq("rst_busy", o_busy, 0);
        w_reset = 1'b0;
        tick();

        fb[0] = 8'hA5; fd[0] = 0;
        run_frame("single", 1);

        fb[0] = 8'h01; fb[1] = 8'h80; fb[2] = 8'hFF;
        fd[0] = 0; fd[1] = 0; fd[2] = 0;
        run_frame("three", 3);

        fb[0] = 8'h69; fb[1] = 8'h96; fd[0] = 0; fd[1] = 50;
        run_frame("stall", 2);

        // Reset in the fourth SCLK-high phase
        r0 = rises; x0 = rx_q.size(); n = 0;
        send(8'hC3, 1'b1, 0);
        while ((rises - r0) < 4 && n < BUDGET) begin tick(); n++; end
        check_eq("abort_rise4", rises - r0, 4);
        w_reset = 1'b1;
        tick();
        check_eq("abort_cs_n", o_spi_cs_n, 1);
        check_eq("abort_sclk", o_spi_clk, 0);
        check_eq("abort_mosi", o_spi_mosi, 0);
        check_eq("abort_ready", o_tx_ready, 1);
        check_eq("abort_busy", o_busy, 0);
        check_eq("abort_rx_valid", o_rx_valid, 0);
        check_eq("abort_rx_data", o_rx_data, 0);
        w_reset = 1'b0;
        repeat (20) tick();
        check_eq("abort_no_strobe", rx_q.size() - x0, 0);
        check_eq("abort_cs_stays", o_spi_cs_n, 1);
        fb[0] = 8'h3C; fd[0] = 0;
        run_frame("after_abort", 1);

        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 4);
            fd[0] = 0;
            for (int k = 0; k < n; k++) begin
                fb[k] = 8'($urandom);
                if (k > 0) fd[k] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0;
            end
            run_frame($sformatf("rand%0d", f), n);
        end

        // Fastest divider, MISO tied high
        i_tx_data = 8'h5A; i_tx_last = 1'b1; tx1_valid = 1'b1;
        tick();
        tx1_valid = 1'b0;
        n = 0;
        while (!sclk1 && n < 100) begin tick(); n++; end
        check_eq("div1_start", sclk1, 1);
        flips = 0; strobes = 0; mb = 8'd0; rxb = 8'd0;
        for (int i = 0; i < 16; i++) begin
            if (sclk1 != (i % 2 == 0)) flips++;
            if (sclk1) mb = {mb[6:0], mosi1};
            if (rx_valid1) begin strobes++; rxb = rx_data1; end
            tick();
        end
        check_eq("div1_toggle", flips, 0);
        check_eq("div1_mosi", mb, 8'h5A);
        check_eq("div1_strobes", strobes, 1);
        check_eq("div1_rx", rxb, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
